dragon_hit_tracker: RTL and testbench



---
 rtl/dragon_hit_tracker_pkg.sv | 23 ++
 rtl/dragon_hit_tracker_rect_overlap.sv | 33 +++
 rtl/dragon_hit_tracker.sv | 156 +++++++++++++++
 tb/tb_dragon_hit_tracker.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dragon_hit_tracker_pkg.sv
// rtl/dragon_hit_tracker_pkg.sv - shared game constants, sprite sizes and dragon state encodings
//
// Shared by the dragon tracker, the missile block and the VGA renderer so
// that every block agrees on the sprite boxes and the screen size.
package dragon_hit_tracker_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Sprite bounding boxes in pixels
  localparam int D_W = 60;
  localparam int D_H = 60;
  localparam int M_W = 20;
  localparam int M_H = 10;

  // 2'b11 is unused and is recovered to ALIVE by the tracker
  typedef enum logic [1:0] {
    ST_ALIVE = 2'b00,
    ST_HIT   = 2'b01,
    ST_DEAD  = 2'b10
  } dragon_state_t;

endpackage

// File: rtl/dragon_hit_tracker_rect_overlap.sv
// rtl/dragon_hit_tracker_rect_overlap.sv - combinational axis-aligned rectangle overlap test
//
// Ports:
//   a_x, a_y  in  10  rectangle A left edge / top edge
//   a_w, a_h  in  10  rectangle A width / height
//   b_x, b_y  in  10  rectangle B left edge / top edge
//   b_w, b_h  in  10  rectangle B width / height
//   overlap   out 1   boxes share at least one pixel
module dragon_hit_tracker_rect_overlap (
  input  logic [9:0] a_x,
  input  logic [9:0] a_y,
  input  logic [9:0] a_w,
  input  logic [9:0] a_h,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  input  logic [9:0] b_w,
  input  logic [9:0] b_h,
  output logic       overlap
);

  // Right/bottom edges are formed in 11 bits so a box near the screen edge
  // cannot wrap around and produce a false overlap.
  logic [10:0] a_r, a_b, b_r, b_b;

  assign a_r = {1'b0, a_x} + {1'b0, a_w};
  assign a_b = {1'b0, a_y} + {1'b0, a_h};
  assign b_r = {1'b0, b_x} + {1'b0, b_w};
  assign b_b = {1'b0, b_y} + {1'b0, b_h};

  assign overlap = (a_r > {1'b0, b_x}) && ({1'b0, a_x} < b_r) &&
                   (a_b > {1'b0, b_y}) && ({1'b0, a_y} < b_b);

endmodule

// File: rtl/dragon_hit_tracker.sv
// rtl/dragon_hit_tracker.sv - dragon position, hit points and life-cycle tracking against the missile
//
// Ports:
//   clk_22        in  1   game tick clock
//   rst           in  1   asynchronous active-low reset
//   pause         in  1   freeze all state, suppress hit_ack
//   m_x, m_y      in  10  missile left edge / top edge
//   show_valid    in  1   missile is on screen
//   d_x, d_y      out 10  dragon left edge / top edge
//   show_dragon   out 1   render enable, blinks while HIT
//   hp            out 3   remaining hit points
//   dragon_state  out 2   00 ALIVE, 01 HIT, 10 DEAD
//   hit_ack       out 1   one-tick pulse after an accepted collision
//   kill_cnt      out 8   kills, saturating at 255
module dragon_hit_tracker
  import dragon_hit_tracker_pkg::*;
#(
  parameter int D_X_FIX       = 520,
  parameter int Y_MIN         = 20,
  parameter int Y_MAX         = 400,
  parameter int Y_STEP        = 10,
  parameter int HP_MAX        = 5,
  parameter int INV_TICKS     = 8,
  parameter int RESPAWN_TICKS = 20
) (
  input  logic       clk_22,
  input  logic       rst,
  input  logic       pause,
  input  logic [9:0] m_x,
  input  logic [9:0] m_y,
  input  logic       show_valid,
  output logic [9:0] d_x,
  output logic [9:0] d_y,
  output logic       show_dragon,
  output logic [2:0] hp,
  output logic [1:0] dragon_state,
  output logic       hit_ack,
  output logic [7:0] kill_cnt
);

  localparam int INV_W  = (INV_TICKS > 1) ? $clog2(INV_TICKS) : 1;
  localparam int RESP_W = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;

  dragon_state_t     state;
  logic              dir_up;
  logic [INV_W-1:0]  inv_cnt;
  logic [RESP_W-1:0] resp_cnt;
  logic              overlap;
  logic              coll;
  logic              active;
  logic [10:0]       y_dn;

  dragon_hit_tracker_rect_overlap u_overlap (
    .a_x     (m_x),
    .a_y     (m_y),
    .a_w     (10'(M_W)),
    .a_h     (10'(M_H)),
    .b_x     (d_x),
    .b_y     (d_y),
    .b_w     (10'(D_W)),
    .b_h     (10'(D_H)),
    .overlap (overlap)
  );

  assign d_x          = 10'(D_X_FIX);
  assign coll         = show_valid && overlap;
  assign active       = (state == ST_ALIVE) || (state == ST_HIT);
  assign y_dn         = {1'b0, d_y} + 11'(Y_STEP);
  assign dragon_state = state;

  always_comb begin
    show_dragon = 1'b1;
    case (state)
      ST_ALIVE: show_dragon = 1'b1;
      ST_HIT:   show_dragon = ~inv_cnt[0];
      ST_DEAD:  show_dragon = 1'b0;
      default:  show_dragon = 1'b1;
    endcase
  end

  always_ff @(posedge clk_22 or negedge rst) begin
    if (!rst) begin
      state    <= ST_ALIVE;
      d_y      <= 10'(Y_MIN);
      dir_up   <= 1'b0;
      hp       <= 3'(HP_MAX);
      inv_cnt  <= '0;
      resp_cnt <= '0;
      hit_ack  <= 1'b0;
      kill_cnt <= '0;
    end else if (pause) begin
      hit_ack <= 1'b0;
    end else begin
      // The ack is taken from the pre-move position, so a collision on a
      // bounce tick is judged where the dragon was drawn.
      hit_ack <= coll && active;

      if (active) begin
        if (!dir_up) begin
          if (y_dn >= 11'(Y_MAX)) begin
            d_y    <= 10'(Y_MAX);
            dir_up <= 1'b1;
          end else begin
            d_y <= y_dn[9:0];
          end
        end else begin
          if ({1'b0, d_y} <= 11'(Y_MIN + Y_STEP)) begin
            d_y    <= 10'(Y_MIN);
            dir_up <= 1'b0;
          end else begin
            d_y <= d_y - 10'(Y_STEP);
          end
        end
      end

      case (state)
        ST_ALIVE: begin
          if (coll) begin
            if (hp > 3'd1) begin
              hp      <= hp - 3'd1;
              state   <= ST_HIT;
              inv_cnt <= '0;
            end else begin
              hp       <= 3'd0;
              state    <= ST_DEAD;
              resp_cnt <= '0;
              if (kill_cnt != 8'hFF) kill_cnt <= kill_cnt + 8'd1;
            end
          end
        end
        ST_HIT: begin
          // Collisions here are acked above but never cost hit points.
          if (inv_cnt == INV_W'(INV_TICKS - 1)) begin
            state   <= ST_ALIVE;
            inv_cnt <= '0;
          end else begin
            inv_cnt <= inv_cnt + 1'b1;
          end
        end
        ST_DEAD: begin
          if (resp_cnt == RESP_W'(RESPAWN_TICKS - 1)) begin
            state    <= ST_ALIVE;
            hp       <= 3'(HP_MAX);
            d_y      <= 10'(Y_MIN);
            dir_up   <= 1'b0;
            resp_cnt <= '0;
          end else begin
            resp_cnt <= resp_cnt + 1'b1;
          end
        end
        default: state <= ST_ALIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_dragon_hit_tracker.sv
// tb/tb_dragon_hit_tracker.sv - scoreboard bench for dragon_hit_tracker with a behavioural game model
module tb_dragon_hit_tracker;

  logic       clk_22 = 1'b0;
  logic       rst = 1'b0;
  logic       pause = 1'b0;
  logic       show_valid = 1'b0;
  logic [9:0] m_x = '0;
  logic [9:0] m_y = '0;
  logic [9:0] d_x, d_y;
  logic       show_dragon;
  logic [2:0] hp;
  logic [1:0] dragon_state;
  logic       hit_ack;
  logic [7:0] kill_cnt;

  dragon_hit_tracker dut (
    .clk_22       (clk_22),
    .rst          (rst),
    .pause        (pause),
    .m_x          (m_x),
    .m_y          (m_y),
    .show_valid   (show_valid),
    .d_x          (d_x),
    .d_y          (d_y),
    .show_dragon  (show_dragon),
    .hp           (hp),
    .dragon_state (dragon_state),
    .hit_ack      (hit_ack),
    .kill_cnt     (kill_cnt)
  );

  always #5 clk_22 = ~clk_22;

  typedef struct {
    int dy;
    int show;
    int hp;
    int st;
    int ack;
    int kills;
  } exp_t;

  exp_t exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  // Game model: phase 0 alive, 1 hit, 2 dead; timers count elapsed ticks.
  int mdl_y, mdl_dir, mdl_hp, mdl_phase, mdl_hit_el, mdl_dead_el, mdl_kills, mdl_ack;

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  function automatic void mdl_reset();
    mdl_y = 20; mdl_dir = 1; mdl_hp = 5; mdl_phase = 0;
    mdl_hit_el = 0; mdl_dead_el = 0; mdl_kills = 0; mdl_ack = 0;
  endfunction

  function automatic void mdl_step(input bit p, input bit sv, input int mx, input int my);
    bit c;
    int old_phase, ny;
    if (p) begin
      mdl_ack = 0;
      return;
    end
    c = sv && (mx + 20 > 520) && (mx < 520 + 60) && (my + 10 > mdl_y) && (my < mdl_y + 60);
    mdl_ack = (c && mdl_phase != 2) ? 1 : 0;
    old_phase = mdl_phase;
    if (old_phase != 2) begin
      ny = mdl_y + 10 * mdl_dir;
      if (ny >= 400) begin mdl_y = 400; mdl_dir = -1; end
      else if (ny <= 20) begin mdl_y = 20; mdl_dir = 1; end
      else mdl_y = ny;
    end
    if (old_phase == 0 && c) begin
      if (mdl_hp > 1) begin
        mdl_hp--; mdl_phase = 1; mdl_hit_el = 0;
      end else begin
        mdl_hp = 0; mdl_phase = 2; mdl_dead_el = 0;
        if (mdl_kills < 255) mdl_kills++;
      end
    end else if (old_phase == 1) begin
      mdl_hit_el++;
      if (mdl_hit_el == 8) begin mdl_phase = 0; mdl_hit_el = 0; end
    end else if (old_phase == 2) begin
      mdl_dead_el++;
      if (mdl_dead_el == 20) begin
        mdl_phase = 0; mdl_hp = 5; mdl_y = 20; mdl_dir = 1; mdl_dead_el = 0;
      end
    end
  endfunction

  function automatic exp_t mdl_snap();
    exp_t e;
    e.dy = mdl_y;
    e.show = (mdl_phase == 0) ? 1 : (mdl_phase == 1) ? ((mdl_hit_el % 2 == 0) ? 1 : 0) : 0;
    e.hp = mdl_hp;
    e.st = mdl_phase;
    e.ack = mdl_ack;
    e.kills = mdl_kills;
    return e;
  endfunction

  task automatic tick(input bit r, input bit p, input bit sv, input int mx, input int my);
    @(negedge clk_22);
    rst = r; pause = p; show_valid = sv; m_x = 10'(mx); m_y = 10'(my);
    if (!r) mdl_reset();
    else mdl_step(p, sv, mx, my);
    exp_q.push_back(mdl_snap());
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1, 0, 0, 0, 0);
  endtask

  task automatic hit_once();
    tick(1, 0, 1, 530, mdl_y + 10);
  endtask

  // Monitor: compares every tick against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_22);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("d_x", d_x, 520);
        chk("d_y", d_y, e.dy);
        chk("show_dragon", show_dragon, e.show);
        chk("hp", hp, e.hp);
        chk("dragon_state", dragon_state, e.st);
        chk("hit_ack", hit_ack, e.ack);
        chk("kill_cnt", kill_cnt, e.kills);
      end
    end
  end

  initial begin
    int my;
    mdl_reset();
    repeat (3) tick(0, 0, 0, 0, 0);

    // Free bounce through the bottom limit
    idle(45);

    // Single hit, then blinking invulnerability
    hit_once();
    idle(10);

    // Overlap held through the whole HIT window
    hit_once();
    repeat (9) tick(1, 0, 1, 530, mdl_y + 10);
    idle(3);
    repeat (3) tick(1, 0, 0, 530, mdl_y + 10);

    // Spaced hits until dead, overlap while dead, then respawn
    for (int i = 0; i < 8; i++) begin
      if (mdl_phase == 2) break;
      hit_once();
      idle(10);
    end
    repeat (5) tick(1, 0, 1, 530, mdl_y + 10);
    idle(20);

    // Pause in the middle of HIT with an overlapping missile
    hit_once();
    idle(3);
    repeat (4) tick(1, 1, 1, 530, mdl_y + 10);
    idle(10);

    // Edge geometry on the x axis
    tick(1, 0, 1, 460, mdl_y + 10);
    idle(2);
    tick(1, 0, 1, 580, mdl_y + 10);
    idle(2);
    tick(1, 0, 1, 501, mdl_y + 10);
    idle(10);

    // Randomised play
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 1) == 0) my = $urandom_range(0, 470);
      else begin
        my = mdl_y - 20 + int'($urandom_range(0, 90));
        if (my < 0) my = 0;
      end
      tick(1, ($urandom_range(0, 9) == 0), $urandom_range(0, 1), 440 + int'($urandom_range(0, 180)), my);
    end

    // Drive to DEAD, then asynchronous reset in the middle of a tick
    for (int i = 0; i < 8; i++) begin
      if (mdl_phase == 2) break;
      if (mdl_phase == 0) hit_once();
      idle(10);
    end
    idle(3);
    @(posedge clk_22);
    #3;
    rst = 1'b0;
    #1;
    chk("async_state", dragon_state, 0);
    chk("async_hp", hp, 5);
    chk("async_kill", kill_cnt, 0);
    chk("async_show", show_dragon, 1);
    chk("async_dy", d_y, 20);
    repeat (2) tick(0, 0, 0, 0, 0);
    idle(10);

    repeat (3) @(posedge clk_22);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
